// File: rtl/gpu_pkg.sv
// Shared GPU core types: core pipeline states, LSU states and the LSU timeout bound.
// Pure declarations, no logic and no latency.
// No handshakes here.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_WAITING    = 2'd2,
        LSU_DONE       = 2'd3
    } lsu_state_t;

    localparam int TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/load_store_unit.sv
// Per-thread load/store unit: one LDR/STR request per instruction into a memory controller slot.
// Latency: REQUEST edge -> REQUESTING, next edge valid+WAITING, DONE on the edge ready is sampled.
// Backpressure: valid/address/data held in WAITING until ready (optional LSU_TIMEOUT_EN bound).
module load_store_unit
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 lsu_error
);

    lsu_state_t state;
    logic       is_read;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
    logic [CNT_BITS-1:0] wait_cnt;
`endif

    assign lsu_state = state;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state             <= LSU_IDLE;
            is_read           <= 1'b0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
`ifdef LSU_TIMEOUT_EN
            lsu_error         <= 1'b0;
            wait_cnt          <= '0;
`endif
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (core_state == CORE_REQUEST &&
                        (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                        // Loads win when both decode bits are set.
                        is_read <= decoded_mem_read_enable;
                        state   <= LSU_REQUESTING;
`ifdef LSU_TIMEOUT_EN
                        lsu_error <= 1'b0;
`endif
                    end
                end
                LSU_REQUESTING: begin
                    if (is_read) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= rs[ADDR_BITS-1:0];
                    end else begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= rs[ADDR_BITS-1:0];
                        mem_write_data    <= rt;
                    end
`ifdef LSU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= LSU_WAITING;
                end
                LSU_WAITING: begin
                    if (is_read && mem_read_ready) begin
                        lsu_out        <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        state          <= LSU_DONE;
                    end else if (!is_read && mem_write_ready) begin
                        mem_write_valid <= 1'b0;
                        state           <= LSU_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        lsu_error       <= 1'b1;
                        lsu_out         <= {DATA_BITS{1'b1}};
                        state           <= LSU_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                LSU_DONE: begin
                    if (core_state == CORE_UPDATE) state <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

`ifndef LSU_TIMEOUT_EN
    assign lsu_error = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit against a transaction-level scoreboard.
// Build with +define+LSU_TIMEOUT_EN to exercise the timeout path.
module tb_load_store_unit;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [2:0]  core_state;
    logic        rd_en, wr_en;
    logic [15:0] rs, rt;
    logic        mem_read_valid, mem_read_ready;
    logic [7:0]  mem_read_address;
    logic [15:0] mem_read_data;
    logic        mem_write_valid, mem_write_ready;
    logic [7:0]  mem_write_address;
    logic [15:0] mem_write_data;
    logic [1:0]  lsu_state;
    logic [15:0] lsu_out;
    logic        lsu_error;

    int vectors = 0;
    int miscompares = 0;

    // Scoreboard: what the outputs must show, derived from the transaction history.
    logic [7:0]  m_ra, m_wa;
    logic [15:0] m_wd, m_out;
    logic        m_err;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_BITS(8), .DATA_BITS(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
        .rs(rs), .rt(rt),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
    );

    function automatic logic [52:0] obs();
        return {lsu_state, mem_read_valid, mem_write_valid, mem_read_address,
                mem_write_address, mem_write_data, lsu_out, lsu_error};
    endfunction

    function automatic logic [52:0] expv(input logic [1:0] st, input logic rv, input logic wv);
        return {st, rv, wv, m_ra, m_wa, m_wd, m_out, m_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_ra = '0; m_wa = '0; m_wd = '0; m_out = '0; m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        core_state = CORE_IDLE; rd_en = 0; wr_en = 0;
        mem_read_ready = 0; mem_write_ready = 0;
    endtask

    // Issue one instruction up to WAITING; checks the REQUESTING and issue cycles.
    task automatic issue(input string name, input logic rd, input logic wr,
                         input logic [15:0] rs_v, input logic [15:0] rt_v);
        core_state = CORE_REQUEST; rd_en = rd; wr_en = wr; rs = rs_v; rt = rt_v;
        step();
        m_err = 1'b0;
        vectors++;
        if (obs() !== expv(2'd1, 0, 0)) begin
            miscompares++;
            $display("FAIL %s_requesting: got %h want %h", name, obs(), expv(2'd1, 0, 0));
        end
        core_state = CORE_WAIT; rd_en = 0; wr_en = 0;
        step();
        if (rd) m_ra = rs_v[7:0];
        else begin m_wa = rs_v[7:0]; m_wd = rt_v; end
        vectors++;
        if (obs() !== expv(2'd2, rd, !rd)) begin
            miscompares++;
            $display("FAIL %s_issue: got %h want %h", name, obs(), expv(2'd2, rd, !rd));
        end
    endtask

    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [15:0] rs_v, input logic [15:0] rt_v,
                           input int delay, input logic [15:0] data);
        logic is_rd;
        is_rd = rd;
        issue(name, rd, wr, rs_v, rt_v);
        for (int i = 0; i < delay; i++) begin
            // Ready on the direction not issued must be ignored.
            mem_read_ready  = is_rd ? 1'b0 : 1'($urandom);
            mem_write_ready = is_rd ? 1'($urandom) : 1'b0;
            mem_read_data   = 16'($urandom);
            step();
            vectors++;
            if (obs() !== expv(2'd2, is_rd, !is_rd)) begin
                miscompares++;
                $display("FAIL %s_hold%0d: got %h want %h", name, i, obs(), expv(2'd2, is_rd, !is_rd));
            end
        end
        mem_read_ready = is_rd; mem_write_ready = !is_rd; mem_read_data = data;
        step();
        if (is_rd) m_out = data;
        vectors++;
        if (obs() !== expv(2'd3, 0, 0)) begin
            miscompares++;
            $display("FAIL %s_done: got %h want %h", name, obs(), expv(2'd3, 0, 0));
        end
        // Stray ready in DONE must not restart or recapture.
        mem_read_ready = 1; mem_write_ready = 1; mem_read_data = ~data;
        step();
        vectors++;
        if (obs() !== expv(2'd3, 0, 0)) begin
            miscompares++;
            $display("FAIL %s_done_hold: got %h want %h", name, obs(), expv(2'd3, 0, 0));
        end
        mem_read_ready = 0; mem_write_ready = 0; core_state = CORE_UPDATE;
        step();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL %s_update: got %h want %h", name, obs(), expv(2'd0, 0, 0));
        end
        core_state = CORE_IDLE;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; rs = 0; rt = 0; mem_read_data = 0;
        idle_inputs();
        step(); step();
        reset = 0;
        model_clear();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", obs(), expv(2'd0, 0, 0));
        end
    endtask

    task automatic test_ldr();
        run_txn("ldr", 1, 0, 16'h0010, 16'h0000, 3, 16'hABCD);
    endtask

    task automatic test_str();
        run_txn("str", 0, 1, 16'h0020, 16'h5555, 3, 16'h1234);
    endtask

    task automatic test_priority();
        run_txn("both", 1, 1, 16'h0030, 16'h7777, 2, 16'h0F0F);
    endtask

    task automatic test_reset_mid();
        issue("rst_mid", 1, 0, 16'h0044, 16'h0000);
        step();
        reset = 1;
        step();
        reset = 0;
        model_clear();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_mid: got %h want %h", obs(), expv(2'd0, 0, 0));
        end
        core_state = CORE_IDLE; mem_read_ready = 1; mem_read_data = 16'hBEEF;
        step(); step();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_late_ready: got %h want %h", obs(), expv(2'd0, 0, 0));
        end
        mem_read_ready = 0;
    endtask

    task automatic test_enable();
        enable = 0; core_state = CORE_REQUEST; rd_en = 1; rs = 16'h0050;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL enable_low: got %h want %h", obs(), expv(2'd0, 0, 0));
        end
        enable = 1; idle_inputs();
        step();
        run_txn("pre_en", 1, 0, 16'h0061, 16'h0000, 1, 16'h4321);
        issue("en_mid", 0, 1, 16'h0062, 16'h9999);
        enable = 0;
        step();
        model_clear();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL enable_mid: got %h want %h", obs(), expv(2'd0, 0, 0));
        end
        enable = 1; idle_inputs();
        step();
    endtask

    task automatic test_long_wait();
`ifdef LSU_TIMEOUT_EN
        issue("timeout", 1, 0, 16'h0070, 16'h0000);
        for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step();
        vectors++;
        if (obs() !== expv(2'd2, 1, 0)) begin
            miscompares++;
            $display("FAIL timeout_early: got %h want %h", obs(), expv(2'd2, 1, 0));
        end
        step();
        m_err = 1'b1; m_out = 16'hFFFF;
        vectors++;
        if (obs() !== expv(2'd3, 0, 0)) begin
            miscompares++;
            $display("FAIL timeout_fire: got %h want %h", obs(), expv(2'd3, 0, 0));
        end
        core_state = CORE_UPDATE;
        step();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL timeout_update: got %h want %h", obs(), expv(2'd0, 0, 0));
        end
        run_txn("after_to", 0, 1, 16'h0071, 16'h2222, 0, 16'h0000);
`else
        issue("long", 1, 0, 16'h0070, 16'h0000);
        for (int i = 0; i < 300; i++) step();
        vectors++;
        if (obs() !== expv(2'd2, 1, 0)) begin
            miscompares++;
            $display("FAIL long_wait: got %h want %h", obs(), expv(2'd2, 1, 0));
        end
        mem_read_ready = 1; mem_read_data = 16'hC0DE;
        step();
        m_out = 16'hC0DE;
        mem_read_ready = 0; core_state = CORE_UPDATE;
        step();
        vectors++;
        if (obs() !== expv(2'd0, 0, 0)) begin
            miscompares++;
            $display("FAIL long_finish: got %h want %h", obs(), expv(2'd0, 0, 0));
        end
        core_state = CORE_IDLE;
`endif
    endtask

    task automatic test_random();
        logic rd, wr;
        for (int n = 0; n < 25; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) wr = 1'b1;
            run_txn("rand", rd, wr, 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 6)), 16'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_str();
        test_priority();
        test_reset_mid();
        test_enable();
        test_long_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16: memory data and register width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: thread active; when low, the unit holds its reset values.
REQ-006 SHALL have port core_state, input, 3: core pipeline state, coded per pkg.
REQ-007 SHALL have port decoded_mem_read_enable, input, 1: current instruction is LDR.
REQ-008 SHALL have port decoded_mem_write_enable, input, 1: current instruction is STR.
REQ-009 SHALL have port rs, input, DATA_BITS: address register.
REQ-010 SHALL have port rt, input, DATA_BITS: store data register.
REQ-011 SHALL have ports mem_read_valid (output, 1), mem_read_address (output, ADDR_BITS), mem_read_ready (input, 1) and mem_read_data (input, DATA_BITS), forming the read request to one controller consumer slot.
REQ-012 SHALL have ports mem_write_valid (output, 1), mem_write_address (output, ADDR_BITS), mem_write_data (output, DATA_BITS) and mem_write_ready (input, 1), forming the write request to the same slot.
REQ-013 SHALL have port lsu_state, output, 2: IDLE=0, REQUESTING=1, WAITING=2, DONE=3.
REQ-014 SHALL have port lsu_out, output, DATA_BITS: last loaded data.
REQ-015 SHALL have port lsu_error, output, 1: last access timed out.

Function
REQ-016 SHALL leave IDLE only when enable=1, core_state=REQUEST, and read or write enable=1; it then enters REQUESTING on the next edge.
REQ-017 SHALL give read priority when both decoded enables are high; no write is issued for that instruction.
REQ-018 SHALL, in REQUESTING, register valid=1 with address=rs[ADDR_BITS-1:0] (plus data=rt for a write) and enter WAITING on the same edge.
REQ-019 SHALL hold valid, address and data stable throughout WAITING.
REQ-020 SHALL, when the matching ready=1 is sampled in WAITING, capture mem_read_data into lsu_out (reads only), register valid=0 on that edge, and enter DONE.
REQ-021 SHALL never reassert valid until core_state=UPDATE has returned the FSM to IDLE (one request per instruction).
REQ-022 SHALL move from DONE to IDLE on the edge where core_state=UPDATE; lsu_out is retained.
REQ-023 SHALL ignore ready received outside WAITING, and ready for the non-issued direction.
REQ-024 SHALL give minimum latency, with controller ready 3 cycles after valid, of REQUEST edge to DONE in 5 cycles.
REQ-025 SHALL keep a write from modifying lsu_out.

Reset
REQ-026 SHALL, on reset=1 at posedge, set lsu_state=IDLE, both valids=0, addresses/data=0, lsu_out=0 and lsu_error=0, including mid-transaction; the request is dropped, which the controller treats as cancellation.
REQ-027 SHALL, on enable=0, force the same values on the next edge.

Configuration
REQ-028 SHALL, with LSU_TIMEOUT_EN defined, count WAITING cycles; if the count reaches TIMEOUT_CYCLES (pkg, 255) without ready, the unit drops valid, sets lsu_error=1, sets lsu_out={DATA_BITS{1'b1}} and enters DONE.
REQ-029 SHALL clear lsu_error only on reset or on the next entry to REQUESTING.
REQ-030 SHALL, without LSU_TIMEOUT_EN, wait indefinitely in WAITING, omit the counter, and tie lsu_error to 0.

Structure
REQ-031 SHALL place the core_state enum, lsu_state enum and TIMEOUT_CYCLES in the shared package gpu_pkg.
REQ-032 SHALL be a single module; one lsu per thread, each wired to one controller consumer index.

Verification
REQ-033 SHALL cover: LDR with rs=16'h0010, ready+data 16'hABCD after 3 cycles -> read address 8'h10, lsu_out=16'hABCD, DONE, then IDLE after UPDATE.
REQ-034 SHALL cover: STR with rs=16'h0020, rt=16'h5555 -> write address 8'h20, data 16'h5555, valid drops the cycle after ready, lsu_out unchanged.
REQ-035 SHALL cover: both enables high with rs=16'h0030 -> only mem_read_valid asserts, mem_write_valid stays 0.
REQ-036 SHALL cover: reset asserted in WAITING -> valid=0 and lsu_state=0 next edge; a late ready is ignored.
REQ-037 SHALL cover: LSU_TIMEOUT_EN defined, no ready for 255 cycles -> valid drops, lsu_error=1, lsu_out=16'hFFFF, DONE.
REQ-038 SHALL cover: enable=0 with core_state=REQUEST and read enable=1 -> no valid, lsu_state stays 0.
